commit_unit: RTL and testbench

Retirement stage directly downstream of the reorder buffer. It consumes the per-cycle in-order commit stream (commit_e_, commit_rd, commit_data, exception info, flush_) and turns it into:
- architectural register-file writes;
- exception CSR updates (epc/cause);
- a one-shot frontend redirect to the exception handler, followed by a bounded drain window;
- retired-instruction and flush counters.

---
 rtl/commit_unit_pkg.sv | 35 +++
 rtl/commit_drain_fsm.sv | 72 +++++++
 rtl/commit_unit.sv | 114 +++++++++++
 tb/tb_commit_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/commit_unit_pkg.sv
// commit_unit_pkg: shared types and defaults for the retirement stage.
//   RegFile_t       - destination register descriptor
//   ExpCode_t       - exception cause encoding
//   CommitState_t   - commit drain FSM states
//   Width defaults  - data/address width, ROB depth, drain length
package commit_unit_pkg;

    localparam int DataWidth         = 32;
    localparam int AddrWidth         = 32;
    localparam int RobDepth          = 16;
    localparam int CommitDrainCycles = 4;

    typedef struct packed {
        logic [4:0] addr;
    } RegFile_t;

    typedef enum logic [3:0] {
        EXP_INST_MISALIGN = 4'd0,
        EXP_INST_FAULT    = 4'd1,
        EXP_ILLEGAL_INST  = 4'd2,
        EXP_BREAKPOINT    = 4'd3,
        EXP_LOAD_MISALIGN = 4'd4,
        EXP_LOAD_FAULT    = 4'd5,
        EXP_STORE_MISALIGN= 4'd6,
        EXP_STORE_FAULT   = 4'd7,
        EXP_ECALL         = 4'd8
    } ExpCode_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } CommitState_t;

endpackage

// File: rtl/commit_drain_fsm.sv
// commit_drain_fsm: exception redirect + drain sequencer.
//   clk, reset      - clock, async active-high reset
//   exp_take        - an excepting commit is accepted this cycle (only sampled in IDLE)
//   handler_pc      - exception handler address, captured with exp_take
//   state           - current FSM state
//   redirect_e_     - one-cycle frontend redirect strobe (active low, registered)
//   redirect_pc     - redirect target (registered)
//   fe_hold_        - frontend hold through REDIRECT and DRAIN (active low, registered)
//   commit_busy     - high while in REDIRECT or DRAIN (registered)
module commit_drain_fsm
    import commit_unit_pkg::*;
#(
    parameter int ADDR         = AddrWidth,
    parameter int DRAIN_CYCLES = CommitDrainCycles
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exp_take,
    input  logic [ADDR-1:0] handler_pc,
    output CommitState_t    state,
    output logic            redirect_e_,
    output logic [ADDR-1:0] redirect_pc,
    output logic            fe_hold_,
    output logic            commit_busy
);

    CommitState_t state_nxt;
    logic [3:0]   drain_cnt;
    logic [3:0]   drain_cnt_nxt;

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        unique case (state)
            IDLE: begin
                if (exp_take) state_nxt = REDIRECT;
            end
            REDIRECT: begin
                state_nxt     = DRAIN;
                drain_cnt_nxt = 4'(DRAIN_CYCLES - 1);
            end
            DRAIN: begin
                // Leave after the cycle where the counter reads zero, so the
                // drain lasts exactly DRAIN_CYCLES cycles.
                if (drain_cnt == 4'd0) state_nxt = IDLE;
                else                   drain_cnt_nxt = drain_cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they line up with the
    // state register instead of lagging it by a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            redirect_e_ <= 1'b1;
            redirect_pc <= '0;
            fe_hold_    <= 1'b1;
            commit_busy <= 1'b0;
        end else begin
            state       <= state_nxt;
            drain_cnt   <= drain_cnt_nxt;
            redirect_e_ <= (state_nxt != REDIRECT);
            fe_hold_    <= (state_nxt == IDLE);
            commit_busy <= (state_nxt != IDLE);
            if (state == IDLE && exp_take) redirect_pc <= handler_pc;
        end
    end

endmodule

// File: rtl/commit_unit.sv
// commit_unit: retirement stage downstream of the reorder buffer.
//   Inputs : commit_e_/flush_/commit_exp_ (active-low strobes), commit_pc,
//            commit_rd, commit_data, commit_rob_id, commit_exp_code,
//            exp_handler_pc
//   Outputs: arch_we_/arch_waddr/arch_wdata   - architectural regfile write
//            csr_exp_we_/csr_epc/csr_cause    - exception CSR update
//            redirect_e_/redirect_pc/fe_hold_ - handler redirect + drain hold
//            retire_cnt/flush_cnt             - retired / branch-flush counts
//            commit_busy                      - redirect or drain in progress
// All outputs are registered, one cycle after the commit that causes them.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int DATA         = DataWidth,
    parameter int ADDR         = AddrWidth,
    parameter int ROB_DEPTH    = RobDepth,
    parameter int DRAIN_CYCLES = CommitDrainCycles,
    parameter int CNT          = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         commit_e_,
    input  logic                         flush_,
    input  logic [ADDR-1:0]              commit_pc,
    input  RegFile_t                     commit_rd,
    input  logic [DATA-1:0]              commit_data,
    input  logic [$clog2(ROB_DEPTH)-1:0] commit_rob_id,
    input  logic                         commit_exp_,
    input  ExpCode_t                     commit_exp_code,
    input  logic [ADDR-1:0]              exp_handler_pc,
    output logic                         arch_we_,
    output logic [4:0]                   arch_waddr,
    output logic [DATA-1:0]              arch_wdata,
    output logic                         csr_exp_we_,
    output logic [ADDR-1:0]              csr_epc,
    output ExpCode_t                     csr_cause,
    output logic                         redirect_e_,
    output logic [ADDR-1:0]              redirect_pc,
    output logic                         fe_hold_,
    output logic [CNT-1:0]               retire_cnt,
    output logic [CNT-1:0]               flush_cnt,
    output logic                         commit_busy
);

    localparam int ROB = $clog2(ROB_DEPTH);

    CommitState_t state;
    logic         commit_ok;
    logic         retire_ok;
    logic         exp_take;
    logic         wr_ok;

    // Commits are only honoured in IDLE; during redirect/drain the ROB has
    // already flushed, so anything arriving is dropped.
    assign commit_ok = !commit_e_ && (state == IDLE);
    assign retire_ok = commit_ok && commit_exp_;
    assign exp_take  = commit_ok && !commit_exp_;
    assign wr_ok     = retire_ok && (commit_rd.addr != 5'd0);

    commit_drain_fsm #(
        .ADDR         (ADDR),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_drain_fsm (
        .clk         (clk),
        .reset       (reset),
        .exp_take    (exp_take),
        .handler_pc  (exp_handler_pc),
        .state       (state),
        .redirect_e_ (redirect_e_),
        .redirect_pc (redirect_pc),
        .fe_hold_    (fe_hold_),
        .commit_busy (commit_busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arch_we_    <= 1'b1;
            arch_waddr  <= '0;
            arch_wdata  <= '0;
            csr_exp_we_ <= 1'b1;
            csr_epc     <= '0;
            csr_cause   <= ExpCode_t'(4'd0);
            retire_cnt  <= '0;
            flush_cnt   <= '0;
        end else begin
            arch_we_    <= !wr_ok;
            csr_exp_we_ <= !exp_take;
            if (retire_ok) begin
                arch_waddr <= commit_rd.addr;
                arch_wdata <= commit_data;
                retire_cnt <= retire_cnt + CNT'(1);
            end
            // Branch/jump recovery only; an exception with flush_ low is
            // counted as the exception alone.
            if (retire_ok && !flush_) flush_cnt <= flush_cnt + CNT'(1);
            if (exp_take) begin
                csr_epc   <= commit_pc;
                csr_cause <= commit_exp_code;
            end
        end
    end

    // Protocol check: the ROB must not commit while we are redirecting.
    logic [ROB-1:0] bad_rob_id;
    assign bad_rob_id = commit_rob_id;

    always @(posedge clk) begin
        if (!reset && !commit_e_)
            assert (state == IDLE)
            else $warning("commit_unit: commit of rob id %0d during redirect/drain dropped",
                          bad_rob_id);
    end

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;
    import commit_unit_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            commit_e_;
    logic            flush_;
    logic [31:0]     commit_pc;
    RegFile_t        commit_rd;
    logic [31:0]     commit_data;
    logic [3:0]      commit_rob_id;
    logic            commit_exp_;
    ExpCode_t        commit_exp_code;
    logic [31:0]     exp_handler_pc;
    logic            arch_we_;
    logic [4:0]      arch_waddr;
    logic [31:0]     arch_wdata;
    logic            csr_exp_we_;
    logic [31:0]     csr_epc;
    ExpCode_t        csr_cause;
    logic            redirect_e_;
    logic [31:0]     redirect_pc;
    logic            fe_hold_;
    logic [63:0]     retire_cnt;
    logic [63:0]     flush_cnt;
    logic            commit_busy;

    int checks = 0;
    int errors = 0;
    int fe_low = 0;

    always #5 clk = ~clk;

    commit_unit dut (
        .clk             (clk),
        .reset           (reset),
        .commit_e_       (commit_e_),
        .flush_          (flush_),
        .commit_pc       (commit_pc),
        .commit_rd       (commit_rd),
        .commit_data     (commit_data),
        .commit_rob_id   (commit_rob_id),
        .commit_exp_     (commit_exp_),
        .commit_exp_code (commit_exp_code),
        .exp_handler_pc  (exp_handler_pc),
        .arch_we_        (arch_we_),
        .arch_waddr      (arch_waddr),
        .arch_wdata      (arch_wdata),
        .csr_exp_we_     (csr_exp_we_),
        .csr_epc         (csr_epc),
        .csr_cause       (csr_cause),
        .redirect_e_     (redirect_e_),
        .redirect_pc     (redirect_pc),
        .fe_hold_        (fe_hold_),
        .retire_cnt      (retire_cnt),
        .flush_cnt       (flush_cnt),
        .commit_busy     (commit_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs sampled at the next edge; outputs observed 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        commit_e_   = 1'b1;
        flush_      = 1'b1;
        commit_exp_ = 1'b1;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] data,
                          input logic fl_, input logic ex_);
        commit_e_      = 1'b0;
        commit_rd.addr = rd;
        commit_data    = data;
        flush_         = fl_;
        commit_exp_    = ex_;
        commit_rob_id  = commit_rob_id + 4'd1;
    endtask

    initial begin
        reset           = 1'b1;
        commit_pc       = 32'h0;
        commit_rd.addr  = 5'd0;
        commit_data     = 32'h0;
        commit_rob_id   = 4'd0;
        commit_exp_code = EXP_INST_MISALIGN;
        exp_handler_pc  = 32'h0;
        idle_in();
        repeat (3) tick();

        // reset values
        chk("rst_arch_we", arch_we_, 1);
        chk("rst_csr_we", csr_exp_we_, 1);
        chk("rst_redir", redirect_e_, 1);
        chk("rst_hold", fe_hold_, 1);
        chk("rst_busy", commit_busy, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        chk("rst_wdata", arch_wdata, 0);
        chk("rst_rpc", redirect_pc, 0);

        @(negedge clk);
        reset = 1'b0;

        // normal commit
        commit(5'd5, 32'hDEADBEEF, 1'b1, 1'b1);
        tick();
        idle_in();
        chk("wr_we", arch_we_, 0);
        chk("wr_addr", arch_waddr, 5);
        chk("wr_data", arch_wdata, 32'hDEADBEEF);
        chk("wr_retire", retire_cnt, 1);
        chk("wr_csr", csr_exp_we_, 1);
        chk("wr_redir", redirect_e_, 1);
        tick();
        chk("idle_we", arch_we_, 1);
        chk("idle_retire", retire_cnt, 1);

        // x0 write suppressed, still retires
        commit(5'd0, 32'h1234, 1'b1, 1'b1);
        tick();
        idle_in();
        chk("x0_we", arch_we_, 1);
        chk("x0_retire", retire_cnt, 2);

        // mispredict flush
        commit(5'd7, 32'h55, 1'b0, 1'b1);
        tick();
        idle_in();
        chk("fl_cnt", flush_cnt, 1);
        chk("fl_we", arch_we_, 0);
        chk("fl_addr", arch_waddr, 7);
        chk("fl_redir", redirect_e_, 1);
        chk("fl_hold", fe_hold_, 1);
        chk("fl_retire", retire_cnt, 3);

        // exception
        commit_pc       = 32'h100;
        commit_exp_code = EXP_ILLEGAL_INST;
        exp_handler_pc  = 32'h800;
        commit(5'd3, 32'hAAAA, 1'b1, 1'b0);
        tick();
        idle_in();
        chk("ex_csr_we", csr_exp_we_, 0);
        chk("ex_epc", csr_epc, 32'h100);
        chk("ex_cause", csr_cause, EXP_ILLEGAL_INST);
        chk("ex_redir", redirect_e_, 0);
        chk("ex_rpc", redirect_pc, 32'h800);
        chk("ex_busy", commit_busy, 1);
        chk("ex_we", arch_we_, 1);
        chk("ex_retire", retire_cnt, 3);
        fe_low = (fe_hold_ == 1'b0) ? 1 : 0;
        tick();  // first drain cycle
        chk("dr1_redir", redirect_e_, 1);
        chk("dr1_csr", csr_exp_we_, 1);
        fe_low += (fe_hold_ == 1'b0) ? 1 : 0;
        tick();  // second drain cycle: inject an illegal commit
        fe_low += (fe_hold_ == 1'b0) ? 1 : 0;
        commit(5'd9, 32'h99, 1'b0, 1'b1);
        tick();
        idle_in();
        fe_low += (fe_hold_ == 1'b0) ? 1 : 0;
        chk("drc_we", arch_we_, 1);
        chk("drc_retire", retire_cnt, 3);
        chk("drc_flush", flush_cnt, 1);
        chk("drc_csr", csr_exp_we_, 1);
        tick();
        fe_low += (fe_hold_ == 1'b0) ? 1 : 0;
        tick();
        fe_low += (fe_hold_ == 1'b0) ? 1 : 0;
        chk("hold_cycles", 64'(fe_low), 5);
        chk("end_hold", fe_hold_, 1);
        chk("end_busy", commit_busy, 0);

        // exception with flush_ low counts as exception only
        commit_pc       = 32'h204;
        commit_exp_code = EXP_ECALL;
        exp_handler_pc  = 32'hC00;
        commit(5'd4, 32'h1, 1'b0, 1'b0);
        tick();
        idle_in();
        chk("ef_csr_we", csr_exp_we_, 0);
        chk("ef_cause", csr_cause, EXP_ECALL);
        chk("ef_flush", flush_cnt, 1);
        chk("ef_rpc", redirect_pc, 32'hC00);
        tick();  // into drain

        // async reset mid-drain
        #2;
        reset = 1'b1;
        #1;
        chk("ar_hold", fe_hold_, 1);
        chk("ar_busy", commit_busy, 0);
        chk("ar_redir", redirect_e_, 1);
        chk("ar_retire", retire_cnt, 0);
        chk("ar_flush", flush_cnt, 0);
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b0;
        commit(5'd1, 32'hA5, 1'b1, 1'b1);
        tick();
        idle_in();
        chk("post_we", arch_we_, 0);
        chk("post_data", arch_wdata, 32'hA5);
        chk("post_retire", retire_cnt, 1);
        chk("post_hold", fe_hold_, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
